minmaxf_pipe: RTL and testbench
===============================

Name: minmaxf_pipe

Overview:
- Parametrised floating-point min/max unit with valid/ready dataflow handshake on both operands and on the result.
- Successor to the fixed single-stage minimumf. Adds:
  - configurable exponent/fraction widths
  - min or max mode
  - IEEE-754 minimum/maximum vs minNum/maxNum NaN policy
  - an elastic pipeline of configurable depth that stalls per-stage rather than globally
- Used by the arith library wherever the dataflow circuit needs floating-point min/max at a chosen latency.

Parameters:
- EXP_WIDTH, 8, exponent field width.
- FRAC_WIDTH, 23, fraction field width; DATA_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH (derived, not overridable).
- LATENCY, 1, pipeline stages from operand fire to result valid; legal range 1..8.
- IS_MAX, 0, 0 = minimum, 1 = maximum.
- NAN_MODE, 0, 0 = propagate NaN (IEEE minimum/maximum), 1 = prefer number (minNum/maxNum).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- lhs  in  DATA_WIDTH  left operand.
- lhs_valid  in  1  lhs handshake valid.
- lhs_ready  out  1  lhs handshake ready.
- rhs  in  DATA_WIDTH  right operand.
- rhs_valid  in  1  rhs handshake valid.
- rhs_ready  out  1  rhs handshake ready.
- result  out  DATA_WIDTH  min/max result.
- result_valid  out  1  result handshake valid.
- result_ready  in  1  downstream ready.

Behaviour:

Reset
- While rst=0: every stage valid cleared and every stage data register cleared to 0, asynchronously.
- Outputs during and after reset: result_valid=0, result=0. lhs_ready and rhs_ready follow the join rules below; both are 0 while the other operand's valid is 0.
- Reset mid-operation discards all in-flight items with no partial output.

Join
- fire = lhs_valid & rhs_valid & s_ready[0].
- lhs_ready = rhs_valid & s_ready[0]; rhs_ready = lhs_valid & s_ready[0].
- Neither operand is consumed alone.

Pipeline
- Stages 1..LATENCY, each holding a valid bit v[k] and a data register.
- s_ready[k-1] = ~v[k] | s_ready[k]; s_ready[LATENCY] = result_ready.
- Stage k loads from stage k-1 when s_ready[k-1]=1; stage 1 loads on fire.
- A bubble in any stage is filled even while the output is stalled, so up to LATENCY items are held with no loss.
- result = data[LATENCY]; result_valid = v[LATENCY].
- Throughput is one item per cycle when result_ready=1. With no stalls, latency is exactly LATENCY cycles from fire to result_valid.
- Combinational paths: result_ready to lhs_ready/rhs_ready is combinational through the ready chain; the data path carries no combinational input-to-output path.

Arithmetic (evaluated combinationally from lhs/rhs, registered into stage 1)
- NaN: exponent all ones and fraction nonzero. Canonical qNaN: sign 0, exponent all ones, fraction MSB 1, all other fraction bits 0.
- NAN_MODE=0: either operand NaN -> canonical qNaN.
- NAN_MODE=1:
  - exactly one operand NaN -> the other operand, bit-exact.
  - both operands NaN -> canonical qNaN.
- Ordering: sign-magnitude comparison. Negative values order by descending magnitude. Infinities are ordinary extremes.
- Zeros: -0 < +0, so min(+0,-0) = -0 and max(+0,-0) = +0, independent of operand order.
- Equal non-NaN operands: return lhs bits.
- Subnormals compare as-is, with no flush.
- Result bits are always one input's bits exactly, except for canonical NaN.

Boundaries
- Full pipeline with result_ready=0: s_ready[0]=0, so lhs_ready=rhs_ready=0 and no fire.
- result_ready rising with the pipeline full: the pipeline accepts a new operand pair in the same cycle.
- Only one operand valid: no fire, and the held operand must remain stable (upstream contract).

Test Plan:
1. LATENCY=1, IS_MAX=0, lhs=0x3F800000 (1.0), rhs=0x40000000 (2.0), result_ready=1 -> result_valid high exactly 1 cycle after fire, result=0x3F800000; with IS_MAX=1 result=0x40000000.
2. Negatives and zeros, IS_MAX=0:
   - 0xBF800000 vs 0xC0000000 -> 0xC0000000.
   - 0x00000000 vs 0x80000000 -> 0x80000000 in both operand orders.
   - IS_MAX=1 -> 0x00000000.
3. NaN handling, lhs=0x7FC00001, rhs=0x3F800000:
   - NAN_MODE=0 -> 0x7FC00000.
   - NAN_MODE=1 -> 0x3F800000.
   - both operands NaN with NAN_MODE=1 -> 0x7FC00000.
4. LATENCY=3, 8-item stream, result_ready=0 for cycles 4-8 -> exactly 3 items accepted before lhs_ready/rhs_ready drop to 0. After release, all 8 results arrive in order with none lost or duplicated, 1 per cycle.
5. Join skew: lhs_valid held 4 cycles before rhs_valid -> lhs_ready=0 until rhs_valid=1, then a single fire and a single result.
6. LATENCY=4, rst pulled low asynchronously mid-clock with 3 items in flight -> result_valid drops immediately with no clock edge. After release no stale results appear and a new pair yields its result after 4 cycles.

Source files
------------

// File: rtl/minmaxf_pipe.sv
// -----------------------------------------------------------------------------
// minmaxf_pipe
//
// Parametrised floating-point minimum/maximum with a two-operand join on the
// input side and an elastic pipeline of LATENCY stages on the output side.
// Each stage stalls on its own: a bubble is filled even while the output is
// blocked, so the pipeline can hold LATENCY items.
//
// The arithmetic is combinational from lhs/rhs and is registered into stage 1.
// The data path has no combinational input-to-output path. The ready chain
// from result_ready back to lhs_ready/rhs_ready is combinational.
//
// Parameters:
//   EXP_WIDTH   exponent field width
//   FRAC_WIDTH  fraction field width (DATA_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH)
//   LATENCY     pipeline stages from operand fire to result valid (1..8)
//   IS_MAX      0 = minimum, 1 = maximum
//   NAN_MODE    0 = any NaN gives the canonical qNaN
//               1 = prefer the number; two NaNs give the canonical qNaN
//
// Ports:
//   clk                      rising-edge clock
//   rst                      asynchronous, active-low reset
//   lhs, lhs_valid/ready     left operand handshake
//   rhs, rhs_valid/ready     right operand handshake
//   result, result_valid     registered result (last pipeline stage)
//   result_ready             downstream ready
// -----------------------------------------------------------------------------
module minmaxf_pipe #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23,
    parameter int LATENCY    = 1,
    parameter int IS_MAX     = 0,
    parameter int NAN_MODE   = 0,
    localparam int DATA_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] lhs,
    input  logic                  lhs_valid,
    output logic                  lhs_ready,
    input  logic [DATA_WIDTH-1:0] rhs,
    input  logic                  rhs_valid,
    output logic                  rhs_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    input  logic                  result_ready
);

    // Exponent field mask and the canonical quiet NaN:
    // sign 0, exponent all ones, only the fraction MSB set.
    localparam logic [DATA_WIDTH-1:0] EXP_MASK =
        ((DATA_WIDTH'(1'b1) << EXP_WIDTH) - DATA_WIDTH'(1'b1)) << FRAC_WIDTH;
    localparam logic [DATA_WIDTH-1:0] CANON_NAN =
        EXP_MASK | (DATA_WIDTH'(1'b1) << (FRAC_WIDTH - 1));

    // A value is NaN when its exponent is all ones and its fraction is nonzero.
    function automatic logic is_nan(input logic [DATA_WIDTH-1:0] x);
        return ((x & EXP_MASK) == EXP_MASK) &&
               (x[FRAC_WIDTH-1:0] != {FRAC_WIDTH{1'b0}});
    endfunction

    // Sign-magnitude ordering of non-NaN values. When the signs differ, the
    // negative value is smaller, so -0 orders below +0. Among negative values,
    // the larger magnitude is the smaller value.
    function automatic logic less_than(input logic [DATA_WIDTH-1:0] a,
                                       input logic [DATA_WIDTH-1:0] b);
        logic lt;
        if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) begin
            lt = a[DATA_WIDTH-1];
        end else if (a[DATA_WIDTH-1] == 1'b0) begin
            lt = (a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0]);
        end else begin
            lt = (a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0]);
        end
        return lt;
    endfunction

    // Select the min/max according to the NaN policy. Only a strict win moves
    // the choice to b, so equal operands return a (the lhs) bit-exactly.
    function automatic logic [DATA_WIDTH-1:0] select(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] res;
        logic a_nan;
        logic b_nan;
        a_nan = is_nan(a);
        b_nan = is_nan(b);
        if (a_nan && b_nan) begin
            res = CANON_NAN;
        end else if (a_nan || b_nan) begin
            if (NAN_MODE != 32'sd0) begin
                res = a_nan ? b : a;
            end else begin
                res = CANON_NAN;
            end
        end else if (IS_MAX != 32'sd0) begin
            res = less_than(a, b) ? b : a;
        end else begin
            res = less_than(b, a) ? b : a;
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] pick_s;
    logic                  fire_s;
    logic [LATENCY-1:0]    s_ready_s;      // s_ready_s[k-1]: stage k can load
    logic [LATENCY:1]      v_r;            // per-stage valid
    logic [DATA_WIDTH-1:0] data_r [1:LATENCY];
    logic [LATENCY-1:0]    up_v_s;         // up_v_s[k-1]: valid offered to stage k
    logic [DATA_WIDTH-1:0] up_d_s [LATENCY];

    // Combinational min/max of the current operand pair.
    always_comb begin
        pick_s = select(lhs, rhs);
    end

    // Ready chain from the output back to the join. A stage can load when it is
    // empty or when the stage after it can load.
    always_comb begin
        logic rdy;
        rdy       = result_ready;
        s_ready_s = {LATENCY{1'b0}};
        for (int k = LATENCY; k >= 1; k--) begin
            rdy            = ~v_r[k] | rdy;
            s_ready_s[k-1] = rdy;
        end
    end

    // Join: both operands are consumed together, and never one alone.
    always_comb begin
        fire_s    = lhs_valid & rhs_valid & s_ready_s[0];
        lhs_ready = rhs_valid & s_ready_s[0];
        rhs_ready = lhs_valid & s_ready_s[0];
    end

    // Upstream view for each stage: stage 1 takes the join, and every later
    // stage takes the stage before it.
    always_comb begin
        up_v_s    = {LATENCY{1'b0}};
        up_v_s[0] = fire_s;
        up_d_s[0] = pick_s;
        for (int k = 1; k < LATENCY; k++) begin
            up_v_s[k] = v_r[k];
            up_d_s[k] = data_r[k];
        end
    end

    // Pipeline stages. Each stage loads independently when its ready is high.
    // The data register loads only with a valid item, so it keeps its cleared
    // value until real data arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_r <= {LATENCY{1'b0}};
            for (int k = 1; k <= LATENCY; k++) begin
                data_r[k] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int k = 1; k <= LATENCY; k++) begin
                if (s_ready_s[k-1]) begin
                    v_r[k] <= up_v_s[k-1];
                    if (up_v_s[k-1]) begin
                        data_r[k] <= up_d_s[k-1];
                    end else begin
                        data_r[k] <= data_r[k];
                    end
                end else begin
                    v_r[k]    <= v_r[k];
                    data_r[k] <= data_r[k];
                end
            end
        end
    end

    // Output is taken straight from the last stage's registers.
    always_comb begin
        result       = data_r[LATENCY];
        result_valid = v_r[LATENCY];
    end

endmodule

// File: tb/tb_minmaxf_pipe.sv
// Bench for minmaxf_pipe. It runs four instances that share the operand data
// but have their own handshakes:
//   0: LATENCY=1 min NAN_MODE=0
//   1: LATENCY=1 max NAN_MODE=1
//   2: LATENCY=3 min NAN_MODE=1
//   3: LATENCY=4 max NAN_MODE=0
// A reference model orders values as signed integer keys and feeds one
// scoreboard per instance. Directed steps add fixed expected constants.
module tb_minmaxf_pipe;

    localparam int N = 4;
    localparam int LAT  [N] = '{1, 1, 3, 4};
    localparam int MAXM [N] = '{0, 1, 0, 1};
    localparam int NANM [N] = '{0, 1, 1, 0};
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   lhs, rhs;
    logic [N-1:0]  lhs_valid, rhs_valid, lhs_ready, rhs_ready;
    logic [N-1:0]  result_valid, result_ready;
    logic [31:0]   result [N];

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [N][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        minmaxf_pipe #(
            .EXP_WIDTH (8),
            .FRAC_WIDTH(23),
            .LATENCY   (LAT[g]),
            .IS_MAX    (MAXM[g]),
            .NAN_MODE  (NANM[g])
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .lhs         (lhs),
            .lhs_valid   (lhs_valid[g]),
            .lhs_ready   (lhs_ready[g]),
            .rhs         (rhs),
            .rhs_valid   (rhs_valid[g]),
            .rhs_ready   (rhs_ready[g]),
            .result      (result[g]),
            .result_valid(result_valid[g]),
            .result_ready(result_ready[g])
        );
    end

    // Total-order key: positives map to their magnitude, and negatives map
    // below every positive value (-0 -> -1).
    function automatic longint fkey(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? (-m - 64'sd1) : m;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input int mx, input int nm);
        bit an, bn;
        an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (an || bn) begin
            if ((an && bn) || nm == 0) return QNAN;
            return an ? b : a;
        end
        if (mx != 0) return (fkey(b) > fkey(a)) ? b : a;
        return (fkey(b) < fkey(a)) ? b : a;
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0: case ($urandom_range(0, 7))
                   0: return 32'h00000000;
                   1: return 32'h80000000;
                   2: return 32'h7F800000;
                   3: return 32'hFF800000;
                   4: return 32'h3F800000;
                   5: return 32'hBF800000;
                   6: return 32'h00000001;
                   default: return 32'h80000001;
               endcase
            1: return {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
            2: return {1'($urandom_range(0, 1)), 8'h00, 23'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard. It pops on every output handshake and pushes the model result
    // on every fire. Reset discards whatever is in flight.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) exp_q[i].delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (result_valid[i] && result_ready[i]) begin
                    checks++;
                    assert (exp_q[i].size() != 0) else begin
                        errors++;
                        $error("FAIL sb_unexpected: dut %0d observed %h expected none", i, result[i]);
                    end
                    if (exp_q[i].size() != 0) begin
                        logic [31:0] e;
                        e = exp_q[i].pop_front();
                        checks++;
                        assert (result[i] === e) else begin
                            errors++;
                            $error("FAIL sb_value: dut %0d observed %h expected %h", i, result[i], e);
                        end
                    end
                end
                if (lhs_valid[i] && lhs_ready[i])
                    exp_q[i].push_back(model(lhs, rhs, MAXM[i], NANM[i]));
            end
        end
    end

    typedef struct { logic [31:0] l, r, e0, e1; } dir_t;
    dir_t dir [6] = '{
        '{32'hBF800000, 32'hC0000000, 32'hC0000000, 32'hBF800000},
        '{32'h00000000, 32'h80000000, 32'h80000000, 32'h00000000},
        '{32'h80000000, 32'h00000000, 32'h80000000, 32'h00000000},
        '{32'h7FC00001, 32'h3F800000, QNAN,         32'h3F800000},
        '{32'h7FC00001, 32'hFF800001, QNAN,         QNAN},
        '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000}
    };
    logic [31:0] items [8];

    initial begin
        int sent;
        rst = 1'b0; lhs = 32'd0; rhs = 32'd0;
        lhs_valid = '0; rhs_valid = '0; result_ready = '1;
        #2;
        for (int i = 0; i < N; i++) begin
            check("reset_valid", 32'(result_valid[i]), 32'd0);
            check("reset_result", result[i], 32'd0);
            check("reset_lhs_ready", 32'(lhs_ready[i]), 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Join ready rules: each ready follows the other operand's valid.
        rhs_valid = '1;
        @(negedge clk);
        check("join_lhs_ready", 32'(lhs_ready), 32'hF);
        check("join_rhs_ready", 32'(rhs_ready), 32'h0);
        tick();
        rhs_valid = '0;

        // Test 1: 1.0 vs 2.0, one cycle of latency.
        lhs = 32'h3F800000; rhs = 32'h40000000;
        lhs_valid = '1; rhs_valid = '1;
        @(negedge clk);
        check("t1_not_yet", 32'(result_valid[0]), 32'd0);
        tick();
        lhs_valid = '0; rhs_valid = '0;
        @(negedge clk);
        check("t1_valid", 32'(result_valid[0]), 32'd1);
        check("t1_min", result[0], 32'h3F800000);
        check("t1_max", result[1], 32'h40000000);
        repeat (6) tick();

        // Tests 2/3: negatives, zeros, NaN policy, equal operands.
        foreach (dir[j]) begin
            lhs = dir[j].l; rhs = dir[j].r;
            lhs_valid = '1; rhs_valid = '1;
            tick();
            lhs_valid = '0; rhs_valid = '0;
            @(negedge clk);
            check("dir_min_nan0", result[0], dir[j].e0);
            check("dir_max_nan1", result[1], dir[j].e1);
            tick();
        end
        repeat (6) tick();

        // Random stream into every instance, one pair per cycle.
        lhs_valid = '1; rhs_valid = '1;
        for (int c = 0; c < 300; c++) begin
            lhs = rand_op();
            case ($urandom_range(0, 4))
                0: rhs = lhs;
                1: rhs = lhs ^ 32'h80000000;
                default: rhs = rand_op();
            endcase
            tick();
        end
        lhs_valid = '0; rhs_valid = '0;
        repeat (8) tick();

        // Test 5: join skew on instance 0.
        lhs = 32'h3F800000; rhs = 32'hBF800000;
        lhs_valid[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t5_lhs_ready_low", 32'(lhs_ready[0]), 32'd0);
            check("t5_no_result", 32'(result_valid[0]), 32'd0);
            tick();
        end
        rhs_valid[0] = 1'b1;
        @(negedge clk);
        check("t5_fire", 32'(lhs_ready[0] & rhs_ready[0]), 32'd1);
        tick();
        lhs_valid = '0; rhs_valid = '0;
        @(negedge clk);
        check("t5_result", result[0], 32'hBF800000);
        check("t5_valid", 32'(result_valid[0]), 32'd1);
        tick();
        @(negedge clk);
        check("t5_single", 32'(result_valid[0]), 32'd0);
        tick();

        // Test 4: 8-item stream into instance 2, stalled in cycles 4..8.
        for (int k = 0; k < 8; k++) items[k] = rand_op();
        sent = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            result_ready[2] = !(cyc >= 4 && cyc <= 8);
            lhs_valid[2] = (sent < 8);
            rhs_valid[2] = (sent < 8);
            if (sent < 8) begin
                lhs = items[sent];
                rhs = items[7 - sent];
            end
            @(negedge clk);
            if (cyc == 4) begin
                check("t4_accepted", 32'(sent), 32'd3);
                check("t4_ready_drop", 32'(lhs_ready[2] | rhs_ready[2]), 32'd0);
            end
            if (cyc >= 9 && cyc <= 16)
                check("t4_out_rate", 32'(result_valid[2] & result_ready[2]), 32'd1);
            if (cyc == 17)
                check("t4_drained", 32'(result_valid[2]), 32'd0);
            if (lhs_valid[2] && lhs_ready[2]) sent++;
            tick();
        end
        check("t4_total", 32'(sent), 32'd8);
        lhs_valid = '0; rhs_valid = '0; result_ready = '1;

        // Test 6: asynchronous reset with three items in flight in instance 3.
        result_ready[3] = 1'b0;
        lhs_valid[3] = 1'b1; rhs_valid[3] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lhs = rand_op(); rhs = rand_op();
            tick();
        end
        lhs_valid = '0; rhs_valid = '0;
        tick();
        @(negedge clk);
        check("t6_in_flight", 32'(result_valid[3]), 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_async_valid", 32'(result_valid[3]), 32'd0);
        check("t6_async_result", result[3], 32'd0);
        tick();
        rst = 1'b1; result_ready = '1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("t6_no_stale", 32'(result_valid[3]), 32'd0);
            tick();
        end
        lhs = 32'h40000000; rhs = 32'hC0000000;
        lhs_valid[3] = 1'b1; rhs_valid[3] = 1'b1;
        tick();
        lhs_valid = '0; rhs_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("t6_latency", 32'(result_valid[3]), (k == 4) ? 32'd1 : 32'd0);
            if (k == 4) check("t6_result", result[3], 32'h40000000);
            tick();
        end
        repeat (4) tick();

        for (int i = 0; i < N; i++)
            check("sb_empty", 32'(exp_q[i].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
